// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the framed UART transmit arbiter.
package uart_arb_pkg;

  // Default frame length width, matching the wrapper's length FIFO.
  localparam int LEN_W_DEF = 16;

  // Idle counter width; wide enough for the largest timeout (65535).
  localparam int TO_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_END,
    S_GAP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after last+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // Walk from the lowest priority slot to the highest so the nearest request wins.
  // NOTE: every variable written in this block gets a default first, so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        grant             = '0;
        grant[IDX_W'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one framed UART transmit path between NUM_REQ requesters, one frame at a time.
module uart_tx_frame_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  input  logic [NUM_REQ*8-1:0]     data_i,
  input  logic [NUM_REQ-1:0]       data_valid_i,
  output logic [NUM_REQ-1:0]       data_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     timeout_o,
  output logic                     uart_tx_wren_start_o,
  output logic                     fifo_uart_tx_wren_o,
  output logic                     fifo_uart_tx_wren_r1_o,
  output logic [7:0]               fifo_uart_tx_data_o,
  output logic                     uart_tx_wren_end_o,
  input  logic                     fifo_uart_tx_prog_full_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, arb_grant;
  logic [IDX_W-1:0]   gidx_q, last_q, arb_idx;
  logic [LEN_W-1:0]   remain_q;
  logic [TO_W-1:0]    idle_q;
  logic               to_flag_q;
  logic               wren_r1_q;
  logic [7:0]         data_q;
  logic               accept;
  logic               timeout_hit;

  logic [7:0]         data_a [NUM_REQ];
  logic [LEN_W-1:0]   len_a  [NUM_REQ];

  // Unpack the flat per-requester buses so the owner can be indexed directly.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_a[k] = data_i[k*8 +: 8];
    assign len_a[k]  = len_i[k*LEN_W +: LEN_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_i),
    .last  (last_q),
    .grant (arb_grant)
  );

  // Index of the picked requester, for selecting its length and data.
  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) arb_idx = IDX_W'(k);
    end
  end

  // Ready is combinational from prog_full, so backpressure stops the byte this cycle.
  assign accept      = (state_q == S_XFER) && data_valid_i[gidx_q] && !fifo_uart_tx_prog_full_i;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == S_XFER) && !accept
                       && (idle_q == TO_W'(TIMEOUT_CYC - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and frame strobes.
  always_comb begin
    state_d              = state_q;
    uart_tx_wren_start_o = 1'b0;
    uart_tx_wren_end_o   = 1'b0;
    done_o               = '0;
    timeout_o            = 1'b0;
    data_ready_o         = '0;
    case (state_q)
      S_IDLE: if (|req_i) state_d = S_START;
      S_START: begin
        // A zero-length frame is skipped without touching the wrapper.
        if (remain_q == '0) begin
          state_d = S_GAP;
        end else begin
          uart_tx_wren_start_o = 1'b1;
          state_d              = S_XFER;
        end
      end
      S_XFER: begin
        data_ready_o[gidx_q] = !fifo_uart_tx_prog_full_i;
        if ((accept && remain_q == LEN_W'(1)) || timeout_hit) state_d = S_END;
      end
      S_END: begin
        uart_tx_wren_end_o = 1'b1;
        state_d            = S_GAP;
      end
      S_GAP: begin
        done_o    = grant_q;
        timeout_o = to_flag_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame bookkeeping: owner, remaining length, idle counter and the delayed write.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      remain_q  <= '0;
      idle_q    <= '0;
      to_flag_q <= 1'b0;
      wren_r1_q <= 1'b0;
      data_q    <= '0;
    end else begin
      wren_r1_q <= accept;
      if (accept) data_q <= data_a[gidx_q];
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            grant_q   <= arb_grant;
            gidx_q    <= arb_idx;
            remain_q  <= len_a[arb_idx];
            idle_q    <= '0;
            to_flag_q <= 1'b0;
          end
        end
        S_XFER: begin
          if (accept) begin
            remain_q <= remain_q - 1'b1;
            idle_q   <= '0;
          end else begin
            if (idle_q != '1) idle_q <= idle_q + 1'b1;
            if (timeout_hit)  to_flag_q <= 1'b1;
          end
        end
        S_GAP: begin
          last_q  <= gidx_q;
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant_o                = grant_q;
  assign fifo_uart_tx_wren_o    = accept;
  assign fifo_uart_tx_wren_r1_o = wren_r1_q;
  assign fifo_uart_tx_data_o    = data_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter: frame timing, round-robin order,
// backpressure, zero-length skip, timeout close and mid-frame reset.
module tb_uart_tx_frame_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 16;
  localparam int TO_CYC  = 16;

  logic                     sys_clk_i = 1'b0;
  logic                     rst_n_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*LEN_W-1:0] len_i;
  logic [NUM_REQ*8-1:0]     data_i;
  logic [NUM_REQ-1:0]       data_valid_i;
  logic [NUM_REQ-1:0]       data_ready_o;
  logic [NUM_REQ-1:0]       grant_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     timeout_o;
  logic                     start_o;
  logic                     wren_o;
  logic                     wren_r1_o;
  logic [7:0]               fdata_o;
  logic                     end_o;
  logic                     prog_full;

  uart_tx_frame_arbiter #(
    .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .sys_clk_i                (sys_clk_i),
    .rst_n_i                  (rst_n_i),
    .req_i                    (req_i),
    .len_i                    (len_i),
    .data_i                   (data_i),
    .data_valid_i             (data_valid_i),
    .data_ready_o             (data_ready_o),
    .grant_o                  (grant_o),
    .done_o                   (done_o),
    .timeout_o                (timeout_o),
    .uart_tx_wren_start_o     (start_o),
    .fifo_uart_tx_wren_o      (wren_o),
    .fifo_uart_tx_wren_r1_o   (wren_r1_o),
    .fifo_uart_tx_data_o      (fdata_o),
    .uart_tx_wren_end_o       (end_o),
    .fifo_uart_tx_prog_full_i (prog_full)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // ---------------- requester byte sources ----------------
  logic [7:0]         src_mem [NUM_REQ][32];
  int                 src_n   [NUM_REQ] = '{default: 0};
  int                 src_ptr [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] acc_q = '0;

  always_comb begin
    data_valid_i = '0;
    data_i       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      data_valid_i[k]  = src_ptr[k] < src_n[k];
      data_i[k*8 +: 8] = src_mem[k][5'(src_ptr[k])];
    end
  end

  always @(posedge sys_clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc_q[k]) src_ptr[k] <= src_ptr[k] + 1;
    end
  end

  // ---------------- event monitor (samples on the falling edge) ----------------
  int cyc = 0;
  int t0 = 0;
  int test_id = 0;
  int seen_id = 0;
  int start_q[$], wren_q[$], r1_q[$], r1d_q[$], end_q[$], done_q[$], didx_q[$], to_q[$];

  always @(posedge sys_clk_i) cyc <= cyc + 1;

  function automatic int oh2i(input logic [NUM_REQ-1:0] oh);
    int r = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (oh[k]) r = k;
    return r;
  endfunction

  always @(negedge sys_clk_i) begin
    if (seen_id != test_id) begin
      start_q.delete(); wren_q.delete(); r1_q.delete(); r1d_q.delete();
      end_q.delete(); done_q.delete(); didx_q.delete(); to_q.delete();
      seen_id <= test_id;
    end
    if (start_o)   start_q.push_back(cyc - t0);
    if (wren_o)    wren_q.push_back(cyc - t0);
    if (wren_r1_o) begin r1_q.push_back(cyc - t0); r1d_q.push_back(int'(fdata_o)); end
    if (end_o)     end_q.push_back(cyc - t0);
    if (|done_o)   begin done_q.push_back(cyc - t0); didx_q.push_back(oh2i(done_o)); end
    if (timeout_o) to_q.push_back(cyc - t0);
    acc_q <= data_valid_i & data_ready_o;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 32'(grant_o), 0);
    check({tag, "_ready"}, 32'(data_ready_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_strobes"}, 32'({timeout_o, start_o, wren_o, wren_r1_o, end_o}), 0);
    check({tag, "_data"},  32'(fdata_o), 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic add_byte(input int k, input logic [7:0] b);
    src_mem[k][5'(src_n[k])] = b;
    src_n[k] = src_n[k] + 1;
  endtask

  task automatic set_len(input int k, input int len);
    len_i[k*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic start_test(input logic [NUM_REQ-1:0] reqs);
    req_i   = reqs;
    t0      = cyc;
    test_id = test_id + 1;
  endtask

  // Wait for n done pulses, then drop every request within the GAP cycle.
  task automatic wait_done(input string tag, input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      step();
      if (|done_o) seen++;
    end
    req_i = '0;
    check({tag, "_done_in_budget"}, 32'(seen), 32'(n));
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n_i   = 1'b0;
    req_i     = '0;
    len_i     = '0;
    prog_full = 1'b0;

    // Reset state
    step(); step(); step();
    check_quiet("reset");
    rst_n_i = 1'b1;
    step();

    // Four requesters, len=1, continuous: order 0,1,2,3,0, 5 cycles per frame
    for (int k = 0; k < NUM_REQ; k++) set_len(k, 1);
    add_byte(0, 8'hA0); add_byte(0, 8'hA1);
    add_byte(1, 8'hB1); add_byte(2, 8'hC2); add_byte(3, 8'hD3);
    start_test(4'b1111);
    wait_done("rr", 5, 40);
    check("rr_order0", qat(didx_q, 0), 0);
    check("rr_order1", qat(didx_q, 1), 1);
    check("rr_order2", qat(didx_q, 2), 2);
    check("rr_order3", qat(didx_q, 3), 3);
    check("rr_order4", qat(didx_q, 4), 0);
    check("rr_done_cyc0", qat(done_q, 0), 4);
    check("rr_done_cyc4", qat(done_q, 4), 24);
    check("rr_data1", qat(r1d_q, 1), 'hB1);
    check("rr_data4", qat(r1d_q, 4), 'hA1);

    // len=8 from requester 1 with prog_full high for 10 cycles mid-frame
    set_len(1, 8);
    for (int i = 0; i < 8; i++) add_byte(1, 8'(8'h30 + i));
    start_test(4'b0010);
    for (int i = 0; i < 4; i++) step();
    prog_full = 1'b1;
    for (int i = 0; i < 10; i++) step();
    prog_full = 1'b0;
    wait_done("pf", 1, 40);
    cnt = 0;
    foreach (wren_q[i]) if (wren_q[i] >= 4 && wren_q[i] <= 13) cnt++;
    check("pf_no_wren_while_full", cnt, 0);
    check("pf_wren_resume", qat(wren_q, 2), 14);
    check("pf_r1_total", r1_q.size(), 8);
    check("pf_end_cyc", qat(end_q, 0), 20);
    check("pf_end_with_last_r1", qat(r1_q, 7), 20);
    check("pf_last_data", qat(r1d_q, 7), 'h37);
    check("pf_done_cyc", qat(done_q, 0), 21);
    check("pf_no_timeout", to_q.size(), 0);

    // len=0 from requester 2: no strobes, done two cycles after the grant
    set_len(2, 0);
    start_test(4'b0100);
    wait_done("zl", 1, 20);
    check("zl_no_start", start_q.size(), 0);
    check("zl_no_wren", wren_q.size(), 0);
    check("zl_no_end", end_q.size(), 0);
    check("zl_done_cyc", qat(done_q, 0), 2);
    check("zl_done_idx", qat(didx_q, 0), 2);

    // Timeout: requester 3, len=5, only 2 bytes offered
    set_len(3, 5);
    add_byte(3, 8'h51); add_byte(3, 8'h52);
    start_test(4'b1000);
    wait_done("to", 1, 60);
    check("to_wren_last", qat(wren_q, 1), 3);
    check("to_r1_total", r1_q.size(), 2);
    check("to_end_cyc", qat(end_q, 0), 20);
    check("to_done_cyc", qat(done_q, 0), 21);
    check("to_pulse_cyc", qat(to_q, 0), 21);
    check("to_pulse_cnt", to_q.size(), 1);

    // Single requester 0, len=3, bytes 11/22/33
    set_len(0, 3);
    add_byte(0, 8'h11); add_byte(0, 8'h22); add_byte(0, 8'h33);
    start_test(4'b0001);
    wait_done("one", 1, 30);
    check("one_start", qat(start_q, 0), 1);
    check("one_start_cnt", start_q.size(), 1);
    check("one_wren0", qat(wren_q, 0), 2);
    check("one_wren2", qat(wren_q, 2), 4);
    check("one_wren_cnt", wren_q.size(), 3);
    check("one_r1_0", qat(r1_q, 0), 3);
    check("one_r1_2", qat(r1_q, 2), 5);
    check("one_d0", qat(r1d_q, 0), 'h11);
    check("one_d1", qat(r1d_q, 1), 'h22);
    check("one_d2", qat(r1d_q, 2), 'h33);
    check("one_end", qat(end_q, 0), 5);
    check("one_done", qat(done_q, 0), 6);
    check("one_done_idx", qat(didx_q, 0), 0);

    // Reset during XFER: outputs drop at once, requester 0 wins afterwards
    set_len(1, 4);
    for (int i = 0; i < 4; i++) add_byte(1, 8'(8'h61 + i));
    start_test(4'b0010);
    step(); step(); step();
    check("rst_pre_wren", 32'(wren_o), 1);
    rst_n_i = 1'b0;
    req_i   = '0;
    #1;
    check_quiet("rst_mid");
    step(); step();
    rst_n_i = 1'b1;
    set_len(0, 1);
    add_byte(0, 8'h70);
    start_test(4'b0011);
    step();
    check("rst_regrant", 32'(grant_o), 32'(4'b0001));
    wait_done("rst", 1, 20);
    check("rst_done_idx", qat(didx_q, 0), 0);
    check("rst_done_cyc", qat(done_q, 0), 4);
    check("rst_data", qat(r1d_q, 0), 'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
